// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor with signed set-less-than. Carries ripple through one
// CHUNK-bit slice per stage. The result appears STAGES cycles after accept, and the
// whole pipe stalls while the result is held.
// Optional feature: define ADDSUB_SLTU_EN to decode op 2'b10 as unsigned set-less-than.
// Without it, op 2'b10 behaves as ADD.
module pipelined_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Zero,
    output logic             Overflow,
    output logic             Cout
);

    localparam int STAGES = WIDTH / CHUNK;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    // Slot 0 holds captured operands; slot k+1 holds the state after chunk k is summed.
    // Slot STAGES is the output register.
    logic             r_vld [0:STAGES];
    logic [WIDTH-1:0] r_a   [0:STAGES];
    logic [WIDTH-1:0] r_b   [0:STAGES];
    logic [WIDTH-1:0] r_sum [0:STAGES];
    logic             r_c   [0:STAGES];
    logic             r_z   [0:STAGES];
    logic             r_cm  [0:STAGES];
    logic [1:0]       r_op  [0:STAGES];

    logic [CHUNK:0]   w_chunk [0:STAGES-1];
    logic [WIDTH-1:0] w_sum   [0:STAGES-1];
    logic             w_cmsb  [0:STAGES-1];
    logic             w_sub;
    logic             w_adv;

`ifdef ADDSUB_SLTU_EN
    assign w_sub = op[0] | (op == 2'b10);
`else
    assign w_sub = op[0];
`endif

    // Global stall: nothing moves while a result waits for the consumer
    assign w_adv    = !(r_vld[STAGES] && !out_ready);
    assign in_ready = w_adv;

    // Per-stage chunk sum; carry into the chunk MSB is recovered from the sum bit
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_chunk[k] = {1'b0, r_a[k][k*CHUNK +: CHUNK]}
                       + {1'b0, r_b[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, r_c[k]};
            w_cmsb[k]  = w_chunk[k][CHUNK-1] ^ r_a[k][k*CHUNK + CHUNK - 1]
                       ^ r_b[k][k*CHUNK + CHUNK - 1];
            w_sum[k]   = r_sum[k];
            w_sum[k][k*CHUNK +: CHUNK] = w_chunk[k][CHUNK-1:0];
        end
    end

    // Pipeline registers: capture on accept, advance every slot unless stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
                r_z[s]   <= 1'b0;
                r_cm[s]  <= 1'b0;
                r_op[s]  <= 2'b00;
            end
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
                r_a[0]   <= A;
                r_b[0]   <= B ^ {WIDTH{w_sub}};
                r_sum[0] <= '0;
                r_c[0]   <= w_sub;
                r_z[0]   <= 1'b1;
                r_cm[0]  <= 1'b0;
                r_op[0]  <= op;
            end
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k+1] <= r_vld[k];
                // Bubbles leave data untouched so idle slots do not toggle
                if (r_vld[k]) begin
                    r_a[k+1]   <= r_a[k];
                    r_b[k+1]   <= r_b[k];
                    r_sum[k+1] <= w_sum[k];
                    r_c[k+1]   <= w_chunk[k][CHUNK];
                    r_z[k+1]   <= r_z[k] & (w_chunk[k][CHUNK-1:0] == '0);
                    r_cm[k+1]  <= w_cmsb[k];
                    r_op[k+1]  <= r_op[k];
                end
            end
        end
    end

    assign out_valid = r_vld[STAGES];
    assign Zero      = r_z[STAGES];
    assign Cout      = r_c[STAGES];
    assign Overflow  = r_cm[STAGES] ^ r_c[STAGES];

    // Result select: flags always come from the adder, out depends on op
    always_comb begin
        out = r_sum[STAGES];
        if (r_op[STAGES] == 2'b11) begin
            out = {{(WIDTH-1){1'b0}}, r_sum[STAGES][WIDTH-1] ^ Overflow};
        end
`ifdef ADDSUB_SLTU_EN
        else if (r_op[STAGES] == 2'b10) begin
            out = {{(WIDTH-1){1'b0}}, ~r_c[STAGES]};
        end
`endif
    end

endmodule
